// File: rtl/video_pkg.sv
// video_pkg: 640x480@60 timing constants and pixel colour type shared by
// the timing generator and the colour mappers.
package video_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   typedef struct packed {
      logic [3:0] red;
      logic [3:0] green;
      logic [3:0] blue;
   } rgb444_t;

endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters driving the colour mappers, plus one
// register stage aligning colour, syncs, vde and frame pulses for the encoder.
module video_timing_gen #(
   parameter int H_VISIBLE = video_pkg::H_VISIBLE,
   parameter int H_FRONT   = video_pkg::H_FRONT,
   parameter int H_SYNC    = video_pkg::H_SYNC,
   parameter int H_BACK    = video_pkg::H_BACK,
   parameter int V_VISIBLE = video_pkg::V_VISIBLE,
   parameter int V_FRONT   = video_pkg::V_FRONT,
   parameter int V_SYNC    = video_pkg::V_SYNC,
   parameter int V_BACK    = video_pkg::V_BACK
) (
   input  logic       pixel_clk,
   input  logic       reset_n,
   input  logic [3:0] Red_in,
   input  logic [3:0] Green_in,
   input  logic [3:0] Blue_in,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic [3:0] Red,
   output logic [3:0] Green,
   output logic [3:0] Blue,
   output logic       hsync,
   output logic       vsync,
   output logic       vde,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [9:0]         h_q, h_d, v_q, v_d;
   logic [7:0]         frame_count_q, frame_count_d;
   video_pkg::rgb444_t rgb_q, rgb_d;
   logic               hsync_q, hsync_d, vsync_q, vsync_d, vde_q, vde_d;
   logic               frame_tick_q, frame_tick_d;
   logic               h_wrap, frame_end;

   always_comb begin
      h_wrap        = h_q == H_LAST;
      frame_end     = h_wrap && v_q == V_LAST;
      h_d           = h_wrap ? 10'd0 : h_q + 10'd1;
      v_d           = frame_end ? 10'd0 : h_wrap ? v_q + 10'd1 : v_q;
      // Output stage sees the counters before they advance, hence one cycle late.
      vde_d         = h_q < H_VIS && v_q < V_VIS;
      hsync_d       = !(h_q >= HS_FIRST && h_q <= HS_LAST);
      vsync_d       = !(v_q >= VS_FIRST && v_q <= VS_LAST);
      rgb_d         = vde_d ? {Red_in, Green_in, Blue_in} : '0;
      frame_tick_d  = frame_end;
      frame_count_d = frame_count_q + {7'd0, frame_end};
   end

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         h_q           <= '0;
         v_q           <= '0;
         rgb_q         <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         vde_q         <= 1'b0;
         frame_tick_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         rgb_q         <= rgb_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         vde_q         <= vde_d;
         frame_tick_q  <= frame_tick_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign DrawX       = h_q;
   assign DrawY       = v_q;
   assign Red         = rgb_q.red;
   assign Green       = rgb_q.green;
   assign Blue        = rgb_q.blue;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign vde         = vde_q;
   assign frame_tick  = frame_tick_q;
   assign frame_count = frame_count_q;

endmodule
